// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single memory with one write port and
// one registered read port. After reset the memory can be cleared word by
// word. Writes and reads are arbitrated independently, each with its own
// round-robin pointer, and read responses are steered back to the requester
// that issued them.
module mem_port_arbiter #(
  parameter int MEM_WIDTH_BYTES = 8,
  parameter int MEM_DEPTH       = 256,
  parameter int INIT_CLEAR      = 1,
  localparam int W              = MEM_WIDTH_BYTES * 8,
  localparam int AW             = $clog2(MEM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  // requester A
  input  logic                       a_req_in,
  input  logic                       a_write_in,
  input  logic [AW-1:0]              a_addr_in,
  input  logic [W-1:0]               a_wdata_in,
  input  logic [MEM_WIDTH_BYTES-1:0] a_wmask_in,
  output logic                       a_ready_out,
  output logic                       a_rvalid_out,
  output logic [W-1:0]               a_rdata_out,
  // requester B
  input  logic                       b_req_in,
  input  logic                       b_write_in,
  input  logic [AW-1:0]              b_addr_in,
  input  logic [W-1:0]               b_wdata_in,
  input  logic [MEM_WIDTH_BYTES-1:0] b_wmask_in,
  output logic                       b_ready_out,
  output logic                       b_rvalid_out,
  output logic [W-1:0]               b_rdata_out,
  // memory side
  output logic                       mem_write_out,
  output logic [AW-1:0]              mem_write_addr_out,
  output logic [W-1:0]               mem_write_data_out,
  output logic [MEM_WIDTH_BYTES-1:0] mem_write_mask_out,
  output logic                       mem_read_out,
  output logic [AW-1:0]              mem_read_addr_out,
  input  logic [W-1:0]               mem_read_data_in,
  output logic                       init_done_out
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Pointer encoding: 0 = A was granted last, 1 = B was granted last.
  localparam logic SIDE_B = 1'b1;
  // Clear counter is one bit wider than the address so the terminal compare
  // cannot wrap when MEM_DEPTH is a power of two.
  localparam logic [AW:0] CLR_LAST = (AW+1)'(MEM_DEPTH - 1);
  localparam logic [AW:0] CLR_ONE  = (AW+1)'(1);

  state_t        r_state;
  logic [AW:0]   r_clr_cnt;
  logic          r_wr_last;
  logic          r_rd_last;
  logic          r_a_rvalid;
  logic          r_b_rvalid;

  logic w_run;
  logic w_init;
  logic w_a_wr_cand, w_b_wr_cand, w_a_rd_cand, w_b_rd_cand;
  logic w_a_wr_gnt, w_b_wr_gnt, w_a_rd_gnt, w_b_rd_gnt;

  // Reset overrides everything combinationally, so strobes and readies are
  // quiet during the reset cycle regardless of the registered state.
  assign w_run  = (r_state == ST_RUN)  && !reset;
  assign w_init = (r_state == ST_INIT) && !reset;

  assign w_a_wr_cand = a_req_in &&  a_write_in;
  assign w_b_wr_cand = b_req_in &&  b_write_in;
  assign w_a_rd_cand = a_req_in && !a_write_in;
  assign w_b_rd_cand = b_req_in && !b_write_in;

  // On a tie the side opposite the last winner is granted.
  assign w_a_wr_gnt = w_run && w_a_wr_cand && (!w_b_wr_cand || (r_wr_last == SIDE_B));
  assign w_b_wr_gnt = w_run && w_b_wr_cand && (!w_a_wr_cand || (r_wr_last != SIDE_B));
  assign w_a_rd_gnt = w_run && w_a_rd_cand && (!w_b_rd_cand || (r_rd_last == SIDE_B));
  assign w_b_rd_gnt = w_run && w_b_rd_cand && (!w_a_rd_cand || (r_rd_last != SIDE_B));

  assign a_ready_out   = w_a_wr_gnt || w_a_rd_gnt;
  assign b_ready_out   = w_b_wr_gnt || w_b_rd_gnt;
  assign a_rvalid_out  = r_a_rvalid && !reset;
  assign b_rvalid_out  = r_b_rvalid && !reset;
  assign a_rdata_out   = mem_read_data_in;
  assign b_rdata_out   = mem_read_data_in;
  assign init_done_out = w_run;

  // Write port mux: clear sequence during INIT, else the granted writer.
  always_comb begin
    mem_write_out      = 1'b0;
    mem_write_addr_out = '0;
    mem_write_data_out = '0;
    mem_write_mask_out = '0;
    if (w_init) begin
      mem_write_out      = 1'b1;
      mem_write_addr_out = r_clr_cnt[AW-1:0];
      mem_write_mask_out = '1;
    end else if (w_a_wr_gnt) begin
      mem_write_out      = 1'b1;
      mem_write_addr_out = a_addr_in;
      mem_write_data_out = a_wdata_in;
      mem_write_mask_out = a_wmask_in;
    end else if (w_b_wr_gnt) begin
      mem_write_out      = 1'b1;
      mem_write_addr_out = b_addr_in;
      mem_write_data_out = b_wdata_in;
      mem_write_mask_out = b_wmask_in;
    end
  end

  // Read port mux: address of the granted reader.
  always_comb begin
    mem_read_out      = 1'b0;
    mem_read_addr_out = '0;
    if (w_a_rd_gnt) begin
      mem_read_out      = 1'b1;
      mem_read_addr_out = a_addr_in;
    end else if (w_b_rd_gnt) begin
      mem_read_out      = 1'b1;
      mem_read_addr_out = b_addr_in;
    end
  end

  // Control FSM: clear sequencing, round-robin pointers, read-response tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      r_clr_cnt  <= '0;
      r_wr_last  <= SIDE_B;
      r_rd_last  <= SIDE_B;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_rd_gnt;
      r_b_rvalid <= w_b_rd_gnt;
      if (w_a_wr_gnt || w_b_wr_gnt) begin
        r_wr_last <= w_b_wr_gnt;
      end
      if (w_a_rd_gnt || w_b_rd_gnt) begin
        r_rd_last <= w_b_rd_gnt;
      end
      case (r_state)
        ST_INIT: begin
          r_clr_cnt <= r_clr_cnt + CLR_ONE;
          if (r_clr_cnt == CLR_LAST) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule
